product_sign_restore: RTL and testbench
=======================================

# product_sign_restore

Output stage of the pipelined LUT multiplier and the counterpart of the operand sign-strip stage. The front end reduces each 9-bit two's-complement operand to an 8-bit magnitude. This block captures the operand sign bits on the same cycle. It delays their XOR through a LAT-deep pipeline matched to the LUT product path. It then reapplies the sign to the arriving 16-bit unsigned magnitude product, giving a registered 17-bit two's-complement result with a valid strobe.

## Interface
- LAT, 2, cycles from operand presentation (i_op_valid) to arrival of the matching magnitude product on i_mag; legal range 1..8
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- i_ce  input  1  pipeline enable; low freezes every register in the block
- i_op_valid  input  1  operand pair presented to the sign-strip stage this cycle
- i_sign_a  input  1  bit 8 of operand A, sampled with i_op_valid
- i_sign_b  input  1  bit 8 of operand B, sampled with i_op_valid
- i_mag_valid  input  1  LUT path marks i_mag valid
- i_mag  input  16  unsigned magnitude product |A|·|B|, 0..65025
- o_valid  output  1  o_product valid; single-cycle strobe per operand pair
- o_product  output  17  signed product, two's complement
- o_sign  output  1  sign applied to the current o_product (0 when the product is zero)
- o_align_err  output  1  sticky alignment error; present only with PROD_ALIGN_CHECK_EN, otherwise tied 0

## Operation
- Delay line: LAT stages, each holding {valid, sgn}.
  - Stage 0 loads {i_op_valid, i_sign_a ^ i_sign_b}.
  - Stage k loads stage k-1.
  - All stages advance only when i_ce=1.
  - sgn is don't-care when its valid=0, but must still shift deterministically.
- Tail stage (stage LAT-1) is aligned with i_mag by construction.
- On a cycle with i_ce=1 and tail valid=1, the output register loads:
  - i_mag==0 → o_product=0, o_sign=0. Negative zero is never produced.
  - tail sgn=0 → o_product={1'b0,i_mag}, o_sign=0.
  - tail sgn=1 → o_product=~{1'b0,i_mag}+1 (17-bit two's complement), o_sign=1.
  - o_valid=1.
- On a cycle with i_ce=1 and tail valid=0: o_valid=0. o_product and o_sign hold their last value.
- i_ce=0: o_valid, o_product, o_sign and the delay line all hold. A pending o_valid=1 stays asserted until the next i_ce=1 cycle.
- i_mag_valid is ignored for data qualification; the tail valid alone gates the output.
- Back-to-back operands on consecutive cycles are supported at full throughput, one result per cycle.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - delay line valid bits to 0 and sgn bits to 0
  - o_valid=0, o_product=17'd0, o_sign=0, o_align_err=0
- Reset has priority over i_ce.
- Reset mid-operation discards all in-flight pairs. No o_valid is produced for operands presented before or during reset.
- Latency: operand on cycle N (i_ce held 1) → o_valid on cycle N+LAT+1, with o_product registered from i_mag sampled on cycle N+LAT.
- Each i_ce=0 cycle extends latency by exactly one cycle.
- Worst-case values: 255·255 with sgn=1 → o_product=17'h101FF (−65025); with sgn=0 → 17'h0FE01.

## Configuration
- PROD_ALIGN_CHECK_EN defined:
  - On every cycle with i_ce=1, compare i_mag_valid against tail valid.
  - A mismatch sets o_align_err on the next edge. It stays set until rst.
  - Data behaviour is unchanged.
- PROD_ALIGN_CHECK_EN undefined:
  - No comparator and no flop.
  - o_align_err is constant 0.

## Test plan
- Reset: after rst pulse, o_valid=0, o_product=0, o_sign=0, o_align_err=0. Operands presented one cycle before rst release never produce o_valid.
- Sign matrix, LAT=2, i_mag=15:
  - signs (1,0) → o_product=17'h1FFF1 (−15), o_sign=1, o_valid on cycle N+3.
  - signs (1,1) → 17'h0000F, o_sign=0.
  - signs (0,1) → 17'h1FFF1.
- Zero and extremes:
  - i_mag=0 with signs (1,0) → o_product=0, o_sign=0.
  - i_mag=65025 with signs (0,1) → 17'h101FF.
- Throughput: 8 consecutive pairs with alternating signs, i_mag=1..8 → 8 consecutive o_valid strobes, values +1,−2,+3,…,−8 in order.
- Stall: i_ce low for 3 cycles mid-stream → latency grows by 3; no result dropped or duplicated; o_valid held during the stall.
- Alignment (PROD_ALIGN_CHECK_EN): i_mag_valid asserted one cycle early → o_align_err=1 next cycle and stays set until rst. Without the macro, the same stimulus leaves o_align_err=0.

Source files
------------

// File: rtl/product_sign_restore.sv
// Output stage of the pipelined LUT multiplier: delays the operand sign XOR to match the
// LUT latency, then reapplies it to the unsigned magnitude product. Optional: PROD_ALIGN_CHECK_EN.
module product_sign_restore #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ce,
  input  logic        i_op_valid,
  input  logic        i_sign_a,
  input  logic        i_sign_b,
  input  logic        i_mag_valid,
  input  logic [15:0] i_mag,
  output logic        o_valid,
  output logic [16:0] o_product,
  output logic        o_sign,
  output logic        o_align_err
);

  // Zero magnitude never takes a sign, so negative zero cannot appear.
  function automatic logic [16:0] apply_sign(input logic [15:0] mag, input logic sgn);
    logic [16:0] res;
    if (mag == 16'd0) begin
      res = 17'd0;
    end else if (sgn) begin
      res = ~{1'b0, mag} + 17'd1;
    end else begin
      res = {1'b0, mag};
    end
    return res;
  endfunction

  logic [LAT-1:0] vld_r;
  logic [LAT-1:0] sgn_r;
  logic           tail_vld_s;
  logic           tail_sgn_s;
  logic [16:0]    prod_nxt_s;
  logic           sign_nxt_s;

  assign tail_vld_s = vld_r[LAT-1];
  assign tail_sgn_s = sgn_r[LAT-1];

  // Sign delay line, matched to the LUT product latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {LAT{1'b0}};
      sgn_r <= {LAT{1'b0}};
    end else if (i_ce) begin
      vld_r[0] <= i_op_valid;
      sgn_r[0] <= i_sign_a ^ i_sign_b;
      for (int k = 1; k < LAT; k++) begin
        vld_r[k] <= vld_r[k-1];
        sgn_r[k] <= sgn_r[k-1];
      end
    end else begin
      vld_r <= vld_r;
      sgn_r <= sgn_r;
    end
  end

  // Signed result computed from the tail sign and the arriving magnitude.
  always_comb begin
    prod_nxt_s = apply_sign(i_mag, tail_sgn_s);
    sign_nxt_s = 1'b0;
    if (tail_sgn_s && (i_mag != 16'd0)) begin
      sign_nxt_s = 1'b1;
    end else begin
      sign_nxt_s = 1'b0;
    end
  end

  // Output register; data holds when the tail slot is empty or the pipe is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_product <= 17'd0;
      o_sign    <= 1'b0;
    end else if (i_ce) begin
      o_valid <= tail_vld_s;
      if (tail_vld_s) begin
        o_product <= prod_nxt_s;
        o_sign    <= sign_nxt_s;
      end else begin
        o_product <= o_product;
        o_sign    <= o_sign;
      end
    end else begin
      o_valid   <= o_valid;
      o_product <= o_product;
      o_sign    <= o_sign;
    end
  end

`ifdef PROD_ALIGN_CHECK_EN
  logic align_err_r;

  // Sticky flag: the LUT valid must track the tail valid on every enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err_r <= 1'b0;
    end else if (i_ce && (i_mag_valid != tail_vld_s)) begin
      align_err_r <= 1'b1;
    end else begin
      align_err_r <= align_err_r;
    end
  end

  assign o_align_err = align_err_r;
`else
  logic mag_valid_unused_s;
  assign mag_valid_unused_s = i_mag_valid;
  assign o_align_err        = 1'b0;
`endif

endmodule

// File: tb/tb_product_sign_restore.sv
// Directed self-checking bench for product_sign_restore with LAT=2.
module tb_product_sign_restore;

  logic        clk;
  logic        rst;
  logic        i_ce;
  logic        i_op_valid;
  logic        i_sign_a;
  logic        i_sign_b;
  logic        i_mag_valid;
  logic [15:0] i_mag;
  logic        o_valid;
  logic [16:0] o_product;
  logic        o_sign;
  logic        o_align_err;

  int checks;
  int errors;

  product_sign_restore #(.LAT(2)) dut (
    .clk(clk), .rst(rst), .i_ce(i_ce), .i_op_valid(i_op_valid),
    .i_sign_a(i_sign_a), .i_sign_b(i_sign_b), .i_mag_valid(i_mag_valid),
    .i_mag(i_mag), .o_valid(o_valid), .o_product(o_product),
    .o_sign(o_sign), .o_align_err(o_align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then step past the rising edge.
  task automatic cyc(input logic ce, input logic ov, input logic sa, input logic sb,
                     input logic mv, input logic [15:0] mag);
    i_ce = ce; i_op_valid = ov; i_sign_a = sa; i_sign_b = sb;
    i_mag_valid = mv; i_mag = mag;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    checks++;
    if (o_valid !== 1'b0 || o_product !== 17'd0 || o_sign !== 1'b0 || o_align_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b p=%h s=%b e=%b want 0 0 0 0", o_valid, o_product, o_sign, o_align_err);
    end
    // operand in the last reset cycle must be discarded
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard cycle %0d got o_valid=%b want 0", i, o_valid);
      end
    end
  endtask

  task automatic test_sign_matrix();
    logic [1:0]  sg  [5];
    logic [15:0] mg  [5];
    logic [16:0] ep  [5];
    logic        es  [5];
    sg[0] = 2'b10; mg[0] = 16'd15;    ep[0] = 17'h1FFF1; es[0] = 1'b1;
    sg[1] = 2'b11; mg[1] = 16'd15;    ep[1] = 17'h0000F; es[1] = 1'b0;
    sg[2] = 2'b01; mg[2] = 16'd15;    ep[2] = 17'h1FFF1; es[2] = 1'b1;
    sg[3] = 2'b10; mg[3] = 16'd0;     ep[3] = 17'h00000; es[3] = 1'b0;
    sg[4] = 2'b01; mg[4] = 16'd65025; ep[4] = 17'h101FF; es[4] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cyc(1'b1, 1'b1, sg[t][1], sg[t][0], 1'b0, 16'd0);   // cycle N
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);           // N+1
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL sign_early case %0d got o_valid=%b want 0", t, o_valid);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mg[t]);           // N+2, magnitude arrives
      checks++;
      if (o_valid !== 1'b1 || o_product !== ep[t] || o_sign !== es[t]) begin
        errors++;
        $display("FAIL sign_result case %0d got v=%b p=%h s=%b want 1 %h %b", t, o_valid, o_product, o_sign, ep[t], es[t]);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      checks++;
      if (o_valid !== 1'b0 || o_product !== ep[t]) begin
        errors++;
        $display("FAIL sign_hold case %0d got v=%b p=%h want 0 %h", t, o_valid, o_product, ep[t]);
      end
    end
    // positive extreme
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd65025);
    checks++;
    if (o_valid !== 1'b1 || o_product !== 17'h0FE01 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL extreme_pos got v=%b p=%h s=%b want 1 0fe01 0", o_valid, o_product, o_sign);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_p;
    for (int k = 0; k < 11; k++) begin
      cyc(1'b1, (k < 8) ? 1'b1 : 1'b0, (k % 2 == 1) ? 1'b1 : 1'b0, 1'b0,
          (k >= 2 && k < 10) ? 1'b1 : 1'b0, (k >= 2 && k < 10) ? 16'(k - 1) : 16'd0);
      if (k >= 2 && k < 10) begin
        exp_p = (k % 2 == 1) ? (17'd0 - 17'(k - 1)) : 17'(k - 1);
        checks++;
        if (o_valid !== 1'b1 || o_product !== exp_p) begin
          errors++;
          $display("FAIL b2b result %0d got v=%b p=%h want 1 %h", k - 2, o_valid, o_product, exp_p);
        end
      end else begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b idle cycle %0d got o_valid=%b want 0", k, o_valid);
        end
      end
    end
  endtask

  task automatic test_stall();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);   // pair A, negative
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);   // pair B, positive
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
    checks++;
    if (o_valid !== 1'b1 || o_product !== 17'h1FFFB) begin
      errors++;
      $display("FAIL stall_first got v=%b p=%h want 1 1fffb", o_valid, o_product);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd99);
      checks++;
      if (o_valid !== 1'b1 || o_product !== 17'h1FFFB || o_sign !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got v=%b p=%h s=%b want 1 1fffb 1", i, o_valid, o_product, o_sign);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd7);
    checks++;
    if (o_valid !== 1'b1 || o_product !== 17'h00007 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL stall_second got v=%b p=%h s=%b want 1 00007 0", o_valid, o_product, o_sign);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      checks++;
      if (o_valid !== 1'b0 || o_product !== 17'h00007) begin
        errors++;
        $display("FAIL stall_drain cycle %0d got v=%b p=%h want 0 00007", i, o_valid, o_product);
      end
    end
  endtask

  task automatic test_align();
    logic exp_err;
`ifdef PROD_ALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++;
    if (o_align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_clean got %b want 0", o_align_err);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);   // magnitude valid one cycle early
    checks++;
    if (o_align_err !== exp_err) begin
      errors++;
      $display("FAIL align_set got %b want %b", o_align_err, exp_err);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    checks++;
    if (o_align_err !== exp_err || o_product !== 17'h00003) begin
      errors++;
      $display("FAIL align_sticky got e=%b p=%h want %b 00003", o_align_err, o_product, exp_err);
    end
    // reset mid-flight: clears the flag and discards the pending pair
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    checks++;
    if (o_align_err !== 1'b0 || o_product !== 17'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL align_reset got e=%b p=%h v=%b want 0 00000 0", o_align_err, o_product, o_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_discard cycle %0d got o_valid=%b want 0", i, o_valid);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_ce = 1'b0; i_op_valid = 1'b0; i_sign_a = 1'b0; i_sign_b = 1'b0;
    i_mag_valid = 1'b0; i_mag = 16'd0;
    test_reset();
    test_sign_matrix();
    test_back_to_back();
    test_stall();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
